pmci_vdm_tx_pkt_buf: RTL and testbench

Host-side MCTP-over-PCIe VDM transmit packet buffer for the PMCI block. It decodes the VDM FIFO control register (FCR) and packet data register (PDR) MMIO writes and buffers 64-bit packet words in a FIFO. On a start command it streams the buffered packet as one AXI-Stream burst toward the PMCI VDM TX path. It sits directly downstream of the MMIO CSR decode, in the window holding PMCI_VDM_FCR (base + 0x2000) and PMCI_VDM_PDR (base + 0x2008).

---
 rtl/pmci_vdm_tx_pkt_buf.sv | 143 ++++++++++++++
 tb/tb_pmci_vdm_tx_pkt_buf.sv | 309 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pmci_vdm_tx_pkt_buf.sv
`default_nettype none
// ============================================================================
// Module      : pmci_vdm_tx_pkt_buf
// Description : MCTP-over-PCIe VDM transmit packet buffer. Decodes FCR/PDR
//               MMIO writes, buffers 64-bit words in a FIFO and streams one
//               buffered packet per START as a single AXI-Stream burst.
// Revision    : 1.0 - initial release
// ============================================================================
module pmci_vdm_tx_pkt_buf #(
   parameter int DEPTH = 64,
   parameter int CNT_W = $clog2(DEPTH) + 1
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        csr_wr,
   input  logic        csr_rd,
   input  logic [3:0]  csr_addr,
   input  logic [63:0] csr_wdata,
   output logic [63:0] csr_rdata,
   output logic        csr_rvalid,
   output logic        m_tvalid,
   output logic [63:0] m_tdata,
   output logic        m_tlast,
   input  logic        m_tready
);

   localparam int               c_AW       = $clog2(DEPTH);
   localparam logic [3:0]       c_ADDR_FCR = 4'h0;
   localparam logic [3:0]       c_ADDR_PDR = 4'h8;
   localparam logic [CNT_W-1:0] c_DEPTH    = CNT_W'(DEPTH);
   localparam logic [CNT_W-1:0] c_ONE      = CNT_W'(1);

   localparam logic [0:0] c_IDLE = 1'b0;
   localparam logic [0:0] c_SEND = 1'b1;

   logic [0:0]       r_state;
   logic [0:0]       w_state_nxt;
   logic [CNT_W-1:0] r_wr_ptr;
   logic [CNT_W-1:0] r_rd_ptr;
   logic [CNT_W-1:0] r_remaining;
   logic             r_ovf;
   logic [63:0]      r_mem [DEPTH];

   logic             w_busy;
   logic [CNT_W-1:0] w_wcnt;
   logic             w_full;
   logic             w_empty;
   logic             w_fcr_wr;
   logic             w_pdr_wr;
   logic             w_push;
   logic             w_ovf_evt;
   logic             w_start;
   logic             w_flush;
   logic             w_pop;
   logic             w_last_beat;
   logic [63:0]      w_fcr_val;

   // Pointers carry an extra wrap bit, so the difference is the exact count
   assign w_wcnt   = r_wr_ptr - r_rd_ptr;
   assign w_full   = (w_wcnt == c_DEPTH);
   assign w_empty  = (w_wcnt == '0);

   assign w_fcr_wr = csr_wr && (csr_addr == c_ADDR_FCR);
   assign w_pdr_wr = csr_wr && (csr_addr == c_ADDR_PDR);

   // Pushes are refused while a packet is in flight so the burst length is frozen
   assign w_push    = w_pdr_wr && !w_busy && !w_full;
   assign w_ovf_evt = w_pdr_wr && (w_busy || w_full);

   // FLUSH takes priority over START in the same FCR write
   assign w_flush = w_fcr_wr && (r_state == c_IDLE) && csr_wdata[1];
   assign w_start = w_fcr_wr && (r_state == c_IDLE) && !csr_wdata[1]
                    && csr_wdata[0] && !w_empty;

   assign w_pop       = (r_state == c_SEND) && m_tready;
   assign w_last_beat = w_pop && (r_remaining == c_ONE);

   assign w_fcr_val = {32'h0, 16'(w_wcnt), 12'h0, w_busy, r_ovf, 2'b00};

   // FSM state register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) r_state <= c_IDLE;
      else        r_state <= w_state_nxt;
   end

   // FSM next-state logic
   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         c_IDLE:  if (w_start)     w_state_nxt = c_SEND;
         c_SEND:  if (w_last_beat) w_state_nxt = c_IDLE;
         default:                  w_state_nxt = c_IDLE;
      endcase
   end

   // FSM outputs: stream beat is the FIFO head, gated to zero when idle
   always_comb begin
      w_busy   = (r_state == c_SEND);
      m_tvalid = (r_state == c_SEND);
      m_tlast  = (r_state == c_SEND) && (r_remaining == c_ONE);
      m_tdata  = (r_state == c_SEND) ? r_mem[r_rd_ptr[c_AW-1:0]] : 64'h0;
   end

   // FIFO pointers and packet beat counter
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_wr_ptr    <= '0;
         r_rd_ptr    <= '0;
         r_remaining <= '0;
      end else begin
         if (w_push)  r_wr_ptr <= r_wr_ptr + c_ONE;
         if (w_flush) r_rd_ptr <= r_wr_ptr;
         else if (w_pop) r_rd_ptr <= r_rd_ptr + c_ONE;
         if (w_start) r_remaining <= w_wcnt;
         else if (w_pop) r_remaining <= r_remaining - c_ONE;
      end
   end

   // FIFO storage; contents need no reset since the pointers define validity
   always_ff @(posedge clk) begin
      if (w_push) r_mem[r_wr_ptr[c_AW-1:0]] <= csr_wdata;
   end

   // Sticky overflow flag; a new overflow wins over a same-cycle clear
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)                         r_ovf <= 1'b0;
      else if (w_ovf_evt)                 r_ovf <= 1'b1;
      else if (w_fcr_wr && csr_wdata[2])  r_ovf <= 1'b0;
   end

   // Registered read response capturing state of the csr_rd cycle
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         csr_rvalid <= 1'b0;
         csr_rdata  <= 64'h0;
      end else begin
         csr_rvalid <= csr_rd;
         csr_rdata  <= (csr_rd && (csr_addr == c_ADDR_FCR)) ? w_fcr_val : 64'h0;
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_pmci_vdm_tx_pkt_buf.sv
`default_nettype none
// ============================================================================
// Module      : tb_pmci_vdm_tx_pkt_buf
// Description : Scoreboard bench for the VDM TX packet buffer. Stimulus
//               updates a queue-based model; a monitor pops expected stream
//               beats and read responses and compares them.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_pmci_vdm_tx_pkt_buf;

   localparam int DEPTH = 64;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        csr_wr = 1'b0;
   logic        csr_rd = 1'b0;
   logic [3:0]  csr_addr = 4'h0;
   logic [63:0] csr_wdata = 64'h0;
   logic [63:0] csr_rdata;
   logic        csr_rvalid;
   logic        m_tvalid;
   logic [63:0] m_tdata;
   logic        m_tlast;
   logic        m_tready = 1'b0;

   pmci_vdm_tx_pkt_buf #(.DEPTH(DEPTH)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .csr_wr     (csr_wr),
      .csr_rd     (csr_rd),
      .csr_addr   (csr_addr),
      .csr_wdata  (csr_wdata),
      .csr_rdata  (csr_rdata),
      .csr_rvalid (csr_rvalid),
      .m_tvalid   (m_tvalid),
      .m_tdata    (m_tdata),
      .m_tlast    (m_tlast),
      .m_tready   (m_tready)
   );

   always #5 clk = ~clk;

   // Reference model: buffered words, flags, and expected outputs
   logic [63:0] mdl_q[$];
   logic [64:0] exp_q[$];   // {last, data}
   logic [63:0] rd_q[$];
   logic        mdl_busy = 1'b0;
   logic        mdl_ovf  = 1'b0;

   int n_checks = 0;
   int n_fail   = 0;
   int rdy_mode = 0;        // 0 low, 1 high, 2 random, 3 manual, 4 pattern 1,0,0,1

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // Ready generator
   initial begin
      int cyc = 0;
      logic [3:0] pat = 4'b1001;
      forever begin
         @(posedge clk); #1;
         case (rdy_mode)
            0: m_tready = 1'b0;
            1: m_tready = 1'b1;
            2: m_tready = 1'($urandom_range(0, 1));
            4: m_tready = pat[cyc % 4];
            default: ;
         endcase
         cyc++;
      end
   end

   // Monitor: stream beats, stall stability, read responses
   initial begin
      logic        prev_stall = 1'b0;
      logic [63:0] prev_data  = 64'h0;
      logic        prev_last  = 1'b0;
      logic [64:0] e;
      forever begin
         @(negedge clk);
         if (!rst_n) begin
            prev_stall = 1'b0;
         end else begin
            if (prev_stall) begin
               check("hold_valid", 64'(m_tvalid), 64'h1);
               check("hold_data", m_tdata, prev_data);
               check("hold_last", 64'(m_tlast), 64'(prev_last));
            end
            if (m_tvalid && m_tready) begin
               if (exp_q.size() == 0) begin
                  n_checks++; n_fail++;
                  $display("FAIL unexpected_beat: got %h expected none", m_tdata);
               end else begin
                  e = exp_q.pop_front();
                  check("beat_data", m_tdata, e[63:0]);
                  check("beat_last", 64'(m_tlast), 64'(e[64]));
                  if (e[64]) mdl_busy = 1'b0;
               end
            end
            prev_stall = m_tvalid && !m_tready;
            prev_data  = m_tdata;
            prev_last  = m_tlast;
            if (csr_rvalid) begin
               if (rd_q.size() == 0) begin
                  n_checks++; n_fail++;
                  $display("FAIL unexpected_rvalid: got %h expected none", csr_rdata);
               end else begin
                  check("csr_rdata", csr_rdata, rd_q.pop_front());
               end
            end
         end
      end
   end

   // All stimulus tasks are entered and left 1 time unit after a rising edge
   task automatic pdr_write(input logic [63:0] d);
      csr_wr = 1'b1; csr_addr = 4'h8; csr_wdata = d;
      if (mdl_busy || mdl_q.size() == DEPTH) mdl_ovf = 1'b1;
      else mdl_q.push_back(d);
      @(posedge clk); #1;
      csr_wr = 1'b0;
   endtask

   task automatic fcr_write(input logic [63:0] v);
      csr_wr = 1'b1; csr_addr = 4'h0; csr_wdata = v;
      if (v[2]) mdl_ovf = 1'b0;
      if (!mdl_busy) begin
         if (v[1]) mdl_q.delete();
         else if (v[0] && mdl_q.size() > 0) begin
            for (int i = 0; i < mdl_q.size(); i++)
               exp_q.push_back({(i == mdl_q.size() - 1), mdl_q[i]});
            mdl_q.delete();
            mdl_busy = 1'b1;
         end
      end
      @(posedge clk); #1;
      csr_wr = 1'b0;
   endtask

   task automatic csr_read(input logic [3:0] addr);
      int wcnt;
      wcnt = mdl_busy ? exp_q.size() : mdl_q.size();
      if (addr == 4'h0) rd_q.push_back({32'h0, 16'(wcnt), 12'h0, mdl_busy, mdl_ovf, 2'b00});
      else              rd_q.push_back(64'h0);
      csr_rd = 1'b1; csr_addr = addr;
      @(posedge clk); #1;
      csr_rd = 1'b0;
   endtask

   task automatic idle_cycles(input int n);
      repeat (n) begin @(posedge clk); #1; end
   endtask

   task automatic wait_idle();
      int k = 0;
      while (mdl_busy && k < 2000) begin
         @(posedge clk); #1;
         k++;
      end
      if (mdl_busy) begin
         n_checks++; n_fail++;
         $display("FAIL wait_idle_timeout: got busy expected idle");
         mdl_busy = 1'b0;
         exp_q.delete();
      end else begin
         check("idle_tvalid", 64'(m_tvalid), 64'h0);
      end
   endtask

   task automatic push_n(input int n);
      for (int i = 0; i < n; i++) pdr_write({$urandom, $urandom});
   endtask

   initial begin
      // Reset state
      repeat (2) @(posedge clk);
      #1;
      check("rst_tvalid", 64'(m_tvalid), 64'h0);
      check("rst_tlast", 64'(m_tlast), 64'h0);
      check("rst_tdata", m_tdata, 64'h0);
      check("rst_rvalid", 64'(csr_rvalid), 64'h0);
      check("rst_rdata", csr_rdata, 64'h0);
      rst_n = 1'b1;
      rdy_mode = 1;
      idle_cycles(2);
      csr_read(4'h0);

      // Basic 4-word packet, one beat per cycle from the cycle after START
      pdr_write(64'h11); pdr_write(64'h22); pdr_write(64'h33); pdr_write(64'h44);
      csr_read(4'h0);
      fcr_write(64'h1);
      for (int i = 0; i < 4; i++) begin
         check("burst_tvalid", 64'(m_tvalid), 64'h1);
         @(posedge clk); #1;
      end
      check("burst_end_tvalid", 64'(m_tvalid), 64'h0);
      csr_read(4'h0);
      csr_read(4'h8);

      // Same packet with ready pattern 1,0,0,1
      rdy_mode = 4;
      pdr_write(64'h11); pdr_write(64'h22); pdr_write(64'h33); pdr_write(64'h44);
      fcr_write(64'h1);
      wait_idle();
      rdy_mode = 1;
      idle_cycles(1);

      // Overflow on full, W1C, stream the full FIFO
      push_n(DEPTH + 1);
      csr_read(4'h0);
      fcr_write(64'h4);
      csr_read(4'h0);
      fcr_write(64'h1);
      wait_idle();

      // PDR write during SEND is dropped
      rdy_mode = 0;
      idle_cycles(1);
      push_n(3);
      fcr_write(64'h1);
      pdr_write(64'hDEAD_BEEF);
      csr_read(4'h0);
      fcr_write(64'h3);           // ignored while busy
      rdy_mode = 1;
      wait_idle();
      csr_read(4'h0);
      fcr_write(64'h4);

      // START with empty FIFO, then FLUSH beats START
      fcr_write(64'h1);
      for (int i = 0; i < 3; i++) begin
         check("empty_start_tvalid", 64'(m_tvalid), 64'h0);
         @(posedge clk); #1;
      end
      csr_read(4'h0);
      push_n(3);
      fcr_write(64'h3);
      idle_cycles(3);
      csr_read(4'h0);

      // Two 48-word packets crossing the pointer wrap
      for (int p = 0; p < 2; p++) begin
         for (int i = 0; i < 48; i++) pdr_write(64'(p * 1000 + i));
         fcr_write(64'h1);
         wait_idle();
      end

      // Randomized packets
      rdy_mode = 2;
      for (int it = 0; it < 20; it++) begin
         int n;
         n = (($urandom % 6) == 0) ? DEPTH + int'($urandom_range(0, 2)) : int'($urandom_range(1, DEPTH));
         push_n(n);
         if (($urandom % 3) == 0) csr_read(4'h0);
         if (($urandom % 5) == 0) fcr_write(64'h2);
         fcr_write(64'h1 | (($urandom % 2 == 0) ? 64'h4 : 64'h0));
         wait_idle();
         csr_read(4'h0);
      end

      // Reset mid-packet after two beats
      rdy_mode = 3;
      m_tready = 1'b0;
      idle_cycles(1);
      push_n(5);
      fcr_write(64'h1);
      pdr_write(64'h55);          // dropped, sets OVF
      m_tready = 1'b1;
      @(posedge clk);
      @(posedge clk); #1;
      m_tready = 1'b0;
      rst_n = 1'b0;
      mdl_q.delete(); exp_q.delete();
      mdl_busy = 1'b0; mdl_ovf = 1'b0;
      #1;
      check("async_rst_tvalid", 64'(m_tvalid), 64'h0);
      check("async_rst_tlast", 64'(m_tlast), 64'h0);
      @(posedge clk); #1;
      @(posedge clk); #1;
      rst_n = 1'b1;
      idle_cycles(1);
      csr_read(4'h0);
      rdy_mode = 1;
      pdr_write(64'hA1); pdr_write(64'hA2);
      fcr_write(64'h1);
      wait_idle();
      idle_cycles(3);

      check("exp_q_drained", 64'(exp_q.size()), 64'h0);
      check("rd_q_drained", 64'(rd_q.size()), 64'h0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   // Global watchdog
   initial begin
      #5_000_000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

endmodule
`default_nettype wire
